// File: rtl/whack_a_mole_pkg.sv
// Shared constants and helpers for the whack-a-mole game core: segment patterns,
// speed and state encodings, LFSR constants, BCD and mole-position helpers.
package whack_a_mole_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SPEED_1 = 2'd1,
        SPEED_2 = 2'd2,
        SPEED_3 = 2'd3
    } speed_t;

    typedef enum logic {
        PLAY      = 1'b0,
        GAME_OVER = 1'b1
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [4:0]  NUM_LEDS  = 5'd18;
    // Out-of-range marker so the very first mole never collides with a "previous" one
    localparam logic [4:0]  POS_NONE  = 5'd31;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [4:0] mole_pos(input logic [15:0] v, input logic [4:0] prev);
        logic [4:0] p;
        p = (v[4:0] >= NUM_LEDS) ? v[4:0] - NUM_LEDS : v[4:0];
        if (p == prev) begin
            p = (p == NUM_LEDS - 5'd1) ? 5'd0 : p + 5'd1;
        end
        return p;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = (v != 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = (v != 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/whack_a_mole_game_if.sv
// Board-pin bundle of the whack-a-mole core: buttons and switches in, LEDs and
// seven-segment digits out. The game core uses the slave view.
interface whack_a_mole_game_if;
    logic        speed1;
    logic        speed2;
    logic        speed3;
    logic [17:0] switches;
    logic [17:0] leds;
    logic [6:0]  seg_time_tens;
    logic [6:0]  seg_time_ones;
    logic [6:0]  seg_score_thou;
    logic [6:0]  seg_score_hund;
    logic [6:0]  seg_score_tens;
    logic [6:0]  seg_score_ones;
    logic [6:0]  seg_speed;

    modport master (
        output speed1, speed2, speed3, switches,
        input  leds, seg_time_tens, seg_time_ones, seg_score_thou,
               seg_score_hund, seg_score_tens, seg_score_ones, seg_speed
    );

    modport slave (
        input  speed1, speed2, speed3, switches,
        output leds, seg_time_tens, seg_time_ones, seg_score_thou,
               seg_score_hund, seg_score_tens, seg_score_ones, seg_speed
    );
endinterface

// File: rtl/whack_a_mole_game_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}; codes above 9 blank.
module seg7_decoder
    import whack_a_mole_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/whack_a_mole_game.sv
// Whack-a-mole game core: LFSR-placed mole on 18 LEDs, BCD score and countdown,
// three selectable mole speeds. Define MISS_PENALTY_EN to subtract a point per miss.
//
//  state     | meaning
//  PLAY      | moles appear, hits/misses scored, countdown running
//  GAME_OVER | time expired; LEDs dark, mole and time frozen, only speed may change
module whack_a_mole_game
    import whack_a_mole_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int GAME_TIME_S   = 60,
    parameter int MOLE_PERIOD_1 = 50_000_000,
    parameter int MOLE_PERIOD_2 = 30_000_000,
    parameter int MOLE_PERIOD_3 = 15_000_000
) (
    input logic                clk,
    input logic                rst_n,
    whack_a_mole_game_if.slave bus
);
    localparam int MOLE_MAX = (MOLE_PERIOD_1 > MOLE_PERIOD_2) ?
                              ((MOLE_PERIOD_1 > MOLE_PERIOD_3) ? MOLE_PERIOD_1 : MOLE_PERIOD_3) :
                              ((MOLE_PERIOD_2 > MOLE_PERIOD_3) ? MOLE_PERIOD_2 : MOLE_PERIOD_3);
    localparam int MOLE_W = $clog2(MOLE_MAX + 1);
    localparam int PRE_W  = $clog2(CLK_FREQ_HZ + 1);

    localparam logic [MOLE_W-1:0] LAST_1     = MOLE_W'(MOLE_PERIOD_1 - 1);
    localparam logic [MOLE_W-1:0] LAST_2     = MOLE_W'(MOLE_PERIOD_2 - 1);
    localparam logic [MOLE_W-1:0] LAST_3     = MOLE_W'(MOLE_PERIOD_3 - 1);
    localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [3:0]        TIME_TENS  = 4'(GAME_TIME_S / 10);
    localparam logic [3:0]        TIME_ONES  = 4'(GAME_TIME_S % 10);

    logic [2:0]        btn_s1, btn_s2, btn_s3;
    logic [17:0]       sw_s1, sw_s2, sw_s3;
    logic [2:0]        btn_fall;
    logic [17:0]       sw_rise;
    logic              speed_evt;
    speed_t            speed, speed_sel;
    game_state_t       state, next_state;
    logic              playing, ending;
    logic [MOLE_W-1:0] mole_cnt, mole_last;
    logic              wrap, hit, miss;
    logic [15:0]       lfsr, lfsr_next;
    logic [4:0]        prev_pos, pos_new;
    logic [17:0]       leds_q;
    logic [15:0]       score_bcd;
    logic [PRE_W-1:0]  presc;
    logic [3:0]        time_tens, time_ones;
    logic              time_zero;

    // Buttons idle high, so their synchronizers reset to 1 to avoid a phantom press
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            btn_s3 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
            sw_s3  <= '0;
        end else begin
            btn_s1 <= {bus.speed3, bus.speed2, bus.speed1};
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            sw_s1  <= bus.switches;
            sw_s2  <= sw_s1;
            sw_s3  <= sw_s2;
        end
    end

    assign btn_fall  = btn_s3 & ~btn_s2;
    assign sw_rise   = sw_s2 & ~sw_s3;
    assign speed_evt = |btn_fall;
    assign speed_sel = btn_fall[2] ? SPEED_3 : (btn_fall[1] ? SPEED_2 : SPEED_1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= PLAY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        playing    = 1'b0;
        ending     = 1'b0;
        case (state)
            PLAY: begin
                playing = 1'b1;
                if (time_zero) begin
                    next_state = GAME_OVER;
                    ending     = 1'b1;
                end
            end
            GAME_OVER: next_state = GAME_OVER;
            default:   next_state = PLAY;
        endcase
    end

    always_comb begin
        mole_last = LAST_1;
        case (speed)
            SPEED_2: mole_last = LAST_2;
            SPEED_3: mole_last = LAST_3;
            default: mole_last = LAST_1;
        endcase
    end

    // The position is taken from the already-stepped LFSR value
    assign wrap      = playing && !speed_evt && (mole_cnt == mole_last);
    assign lfsr_next = lfsr_step(lfsr);
    assign pos_new   = mole_pos(lfsr_next, prev_pos);
    assign hit       = playing && |(sw_rise & leds_q);
    assign miss      = playing && !hit && |sw_rise;
    assign time_zero = (time_tens == 4'd0) && (time_ones == 4'd0);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            speed    <= SPEED_1;
            mole_cnt <= '0;
            lfsr     <= LFSR_SEED;
            prev_pos <= POS_NONE;
            leds_q   <= '0;
        end else begin
            if (speed_evt) begin
                speed    <= speed_sel;
                mole_cnt <= '0;
            end else if (playing) begin
                mole_cnt <= wrap ? '0 : mole_cnt + 1'b1;
            end
            if (wrap) begin
                lfsr     <= lfsr_next;
                prev_pos <= pos_new;
            end
            // A new mole outranks a same-cycle hit on the old one
            if (ending) begin
                leds_q <= '0;
            end else if (wrap) begin
                leds_q <= 18'd1 << pos_new;
            end else if (hit) begin
                leds_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            score_bcd <= '0;
        end else if (hit) begin
            score_bcd <= bcd_inc(score_bcd);
        end else if (miss) begin
`ifdef MISS_PENALTY_EN
            score_bcd <= bcd_dec(score_bcd);
`else
            score_bcd <= score_bcd;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc     <= PRE_RELOAD;
            time_tens <= TIME_TENS;
            time_ones <= TIME_ONES;
        end else if (playing) begin
            if (presc == '0) begin
                presc <= PRE_RELOAD;
                if (!time_zero) begin
                    if (time_ones == 4'd0) begin
                        time_ones <= 4'd9;
                        time_tens <= time_tens - 4'd1;
                    end else begin
                        time_ones <= time_ones - 4'd1;
                    end
                end
            end else begin
                presc <= presc - 1'b1;
            end
        end
    end

    assign bus.leds = leds_q;

    seg7_decoder u_time_tens  (.bcd(time_tens),         .seg(bus.seg_time_tens));
    seg7_decoder u_time_ones  (.bcd(time_ones),         .seg(bus.seg_time_ones));
    seg7_decoder u_score_thou (.bcd(score_bcd[15:12]),  .seg(bus.seg_score_thou));
    seg7_decoder u_score_hund (.bcd(score_bcd[11:8]),   .seg(bus.seg_score_hund));
    seg7_decoder u_score_tens (.bcd(score_bcd[7:4]),    .seg(bus.seg_score_tens));
    seg7_decoder u_score_ones (.bcd(score_bcd[3:0]),    .seg(bus.seg_score_ones));
    seg7_decoder u_speed      (.bcd({2'b00, speed}),    .seg(bus.seg_speed));

endmodule

// File: tb/tb_whack_a_mole_game.sv
// Self-checking bench for whack_a_mole_game: per-cycle comparison against a
// behavioural game model plus directed checks with hand-computed values.
module tb_whack_a_mole_game;
    localparam int CLK_HZ = 1000;
    localparam int GAME_S = 5;
    localparam int P1 = 200;
    localparam int P2 = 120;
    localparam int P3 = 60;
`ifdef MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    whack_a_mole_game_if bus ();

    whack_a_mole_game #(
        .CLK_FREQ_HZ(CLK_HZ), .GAME_TIME_S(GAME_S),
        .MOLE_PERIOD_1(P1), .MOLE_PERIOD_2(P2), .MOLE_PERIOD_3(P3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen at each rising edge
    logic [17:0] samp_sw  = '0;
    logic [2:0]  samp_btn = 3'b111;
    logic        samp_rst = 1'b1;
    always @(posedge clk) begin
        samp_sw  <= bus.switches;
        samp_btn <= {bus.speed3, bus.speed2, bus.speed1};
        samp_rst <= rst_n;
    end

    // Game model: plain integers; inputs reach the game two clocks after sampling
    int          m_speed, m_cnt, m_lfsr, m_prev, m_pos, m_score, m_time, m_sec_cyc, cyc;
    bit          m_over;
    logic [17:0] h_sw [4];
    logic [2:0]  h_b  [4];

    function automatic int period(input int sp);
        return (sp == 3) ? P3 : ((sp == 2) ? P2 : P1);
    endfunction

    task automatic model_reset();
        m_speed = 1; m_cnt = 0; m_lfsr = 'hACE1; m_prev = -1; m_pos = -1;
        m_score = 0; m_time = GAME_S; m_sec_cyc = 0; m_over = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin
            h_sw[i] = '0;
            h_b[i]  = 3'b111;
        end
    endtask

    task automatic model_step(input logic [17:0] sw, input logic [2:0] btn);
        logic [17:0] rise;
        logic [2:0]  fall;
        bit sp_evt, playing, wrap, hit, miss, ending;
        int p;
        for (int i = 3; i > 0; i--) begin
            h_sw[i] = h_sw[i-1];
            h_b[i]  = h_b[i-1];
        end
        h_sw[0] = sw;
        h_b[0]  = btn;
        rise    = h_sw[2] & ~h_sw[3];
        fall    = h_b[3] & ~h_b[2];
        sp_evt  = (fall != 0);
        playing = !m_over;
        ending  = playing && (m_time == 0);
        wrap    = playing && !sp_evt && (m_cnt + 1 == period(m_speed));
        hit     = playing && (m_pos >= 0) && rise[m_pos];
        miss    = playing && !hit && (rise != 0);
        p = -1;
        if (wrap) begin
            m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
            p = (m_lfsr & 31) % 18;
            if (p == m_prev) p = (p + 1) % 18;
            m_prev = p;
        end
        if (ending)      m_pos = -1;
        else if (wrap)   m_pos = p;
        else if (hit)    m_pos = -1;
        if (sp_evt) begin
            m_cnt   = 0;
            m_speed = fall[2] ? 3 : (fall[1] ? 2 : 1);
        end else if (playing) begin
            m_cnt = wrap ? 0 : m_cnt + 1;
        end
        if (hit)             m_score = (m_score < 9999) ? m_score + 1 : 9999;
        else if (miss && PEN) m_score = (m_score > 0) ? m_score - 1 : 0;
        if (playing) begin
            m_sec_cyc++;
            if (m_sec_cyc == CLK_HZ) begin
                m_sec_cyc = 0;
                if (m_time > 0) m_time--;
            end
        end
        if (ending) m_over = 1;
        cyc++;
    endtask

    // Compare process: step the model for the edge just taken, then check every output
    initial begin
        logic [17:0] exp_leds, prev_leds, last_nz;
        prev_leds = '0;
        last_nz   = '0;
        model_reset();
        forever begin
            @(negedge clk);
            if (samp_rst) begin
                model_reset();
                last_nz = '0;
            end else begin
                model_step(samp_sw, samp_btn);
            end
            exp_leds = (m_pos < 0) ? 18'd0 : (18'd1 << m_pos);
            chk("leds",           bus.leds,           exp_leds);
            chk("seg_time_tens",  bus.seg_time_tens,  seg_tab[m_time / 10]);
            chk("seg_time_ones",  bus.seg_time_ones,  seg_tab[m_time % 10]);
            chk("seg_score_thou", bus.seg_score_thou, seg_tab[m_score / 1000]);
            chk("seg_score_hund", bus.seg_score_hund, seg_tab[(m_score / 100) % 10]);
            chk("seg_score_tens", bus.seg_score_tens, seg_tab[(m_score / 10) % 10]);
            chk("seg_score_ones", bus.seg_score_ones, seg_tab[m_score % 10]);
            chk("seg_speed",      bus.seg_speed,      seg_tab[m_speed]);
            if (bus.leds != 0 && prev_leds == 0) begin
                chk("mole_onehot", $countones(bus.leds), 1);
                if (last_nz != 0) chk("mole_moved", (bus.leds != last_nz), 1);
            end
            if (bus.leds != 0) last_nz = bus.leds;
            prev_leds = bus.leds;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int g;
        bus.speed1 = 1'b1; bus.speed2 = 1'b1; bus.speed3 = 1'b1;
        bus.switches = '0;
        rst_n = 1'b1;
        tick(10);
        rst_n = 1'b0;
        tick(2);
        chk("rst_leds",       bus.leds,           18'h0);
        chk("rst_score_thou", bus.seg_score_thou, 7'h40);
        chk("rst_score_ones", bus.seg_score_ones, 7'h40);
        chk("rst_time_tens",  bus.seg_time_tens,  7'h40);
        chk("rst_time_ones",  bus.seg_time_ones,  7'h12);
        chk("rst_speed",      bus.seg_speed,      7'h79);

        // Speed 2: first mole 120 clocks after the speed takes effect, LFSR 0xE270 -> LED 16
        bus.speed2 = 1'b0;
        tick(2);
        chk("speed2_not_yet", bus.seg_speed, 7'h79);
        tick(1);
        chk("speed2_seg", bus.seg_speed, 7'h24);
        tick(5);
        bus.speed2 = 1'b1;
        tick(114);
        chk("mole_before_wrap", bus.leds, 18'h0);
        tick(1);
        chk("first_mole", bus.leds, 18'h10000);

        bus.switches = 18'h10000;
        tick(3);
        chk("hit_score_ones", bus.seg_score_ones, 7'h79);
        chk("hit_leds_dark",  bus.leds, 18'h0);
        bus.switches = '0;
        tick(3);

        bus.switches = ~18'h10000 & 18'h3FFFF;
        tick(3);
        chk("miss_score_ones", bus.seg_score_ones, PEN ? 7'h40 : 7'h79);
        bus.switches = '0;
        tick(3);

        bus.speed3 = 1'b0;
        tick(3);
        chk("speed3_seg", bus.seg_speed, 7'h30);
        bus.speed3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            g = 0;
            while (!(m_pos >= 0 && m_cnt == 0) && g < 300) begin
                tick(1);
                g++;
            end
            chk("mole_wait", (g < 300), 1);
            if (m_pos >= 0) bus.switches = 18'd1 << m_pos;
            tick(3);
            bus.switches = '0;
            tick(170);
        end
        chk("ten_hits_tens", bus.seg_score_tens, 7'h79);
        chk("ten_hits_ones", bus.seg_score_ones, PEN ? 7'h40 : 7'h79);

        g = 0;
        while (cyc < 5100 && g < 6000) begin
            tick(1);
            g++;
        end
        chk("game_over_wait", (g < 6000), 1);
        chk("over_time_tens", bus.seg_time_tens, 7'h40);
        chk("over_time_ones", bus.seg_time_ones, 7'h40);
        chk("over_leds",      bus.leds, 18'h0);
        bus.switches = 18'h3FFFF;
        tick(4);
        chk("over_score_tens", bus.seg_score_tens, 7'h79);
        chk("over_score_ones", bus.seg_score_ones, PEN ? 7'h40 : 7'h79);
        bus.switches = '0;
        bus.speed1 = 1'b0;
        tick(4);
        chk("over_speed1", bus.seg_speed, 7'h79);
        bus.speed1 = 1'b1;
        tick(3);

        rst_n = 1'b1;
        tick(1);
        chk("rerst_time_tens",  bus.seg_time_tens,  7'h40);
        chk("rerst_time_ones",  bus.seg_time_ones,  7'h12);
        chk("rerst_score_tens", bus.seg_score_tens, 7'h40);
        chk("rerst_score_ones", bus.seg_score_ones, 7'h40);
        rst_n = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
